// File: rtl/dsi_lanes_distributor.sv
// rtl/dsi_lanes_distributor.sv - deals a 32-bit packet byte stream round-robin into 1..4 DSI lane FIFOs
//
// Ports:
//   clk_sys, rst                     single clock, synchronous active-high reset
//   pkt_data/strb/lp/last/valid      packet beat input (byte 0 in [7:0], strb contiguous from bit 0)
//   pkt_ready                        beat accepted when pkt_valid && pkt_ready
//   reg_lanes_number                 active lanes minus 1, latched on the first beat of a packet
//   lanes_fifo_data                  lane i entry in [i*9+8:i*9] = {LP sign, byte}
//   lanes_fifo_write                 per-lane write strobe
//   lanes_fifo_full                  per-lane FIFO full, sampled in the write cycle
//   busy                             packet in progress
//   err                              sticky protocol error (only with DSI_LANES_DISTR_ERR_CHECK_EN)
//
// Optional: define DSI_LANES_DISTR_ERR_CHECK_EN to compile in the strobe protocol checker.

module dsi_lanes_distributor (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [31:0] pkt_data,
  input  logic [3:0]  pkt_strb,
  input  logic        pkt_lp,
  input  logic        pkt_last,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [1:0]  reg_lanes_number,
  output logic [35:0] lanes_fifo_data,
  output logic [3:0]  lanes_fifo_write,
  input  logic [3:0]  lanes_fifo_full,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_e;

  state_e     state_q, state_d;
  logic [7:0] buf_q [8];
  logic [7:0] buf_d [8];
  logic [3:0] count_q, count_d;
  logic [2:0] n_q, n_d;
  logic       lp_q, lp_d;

  logic [2:0] row_w;
  logic [3:0] row_mask;
  logic       row_req;
  logic       emit;
  logic [2:0] emitted;
  logic       accept;
  logic [2:0] acc_n;
  logic [3:0] rem;
  logic [3:0] src;
  logic [3:0] wr_pos;

  // Row emission is driven straight from registered buffer state so that the
  // full flags are honoured in the very cycle the write strobe is presented.
  always_comb begin
    row_w = n_q;
    if (state_q == S_DRAIN && count_q < {1'b0, n_q}) row_w = count_q[2:0];
    case (row_w)
      3'd1:    row_mask = 4'b0001;
      3'd2:    row_mask = 4'b0011;
      3'd3:    row_mask = 4'b0111;
      3'd4:    row_mask = 4'b1111;
      default: row_mask = 4'b0000;
    endcase
    row_req = (state_q == S_FILL && count_q >= {1'b0, n_q}) ||
              (state_q == S_DRAIN && count_q != 4'd0);
    // All-or-nothing: one full target lane stalls the whole row to keep lanes aligned.
    emit    = !rst && row_req && ((lanes_fifo_full & row_mask) == 4'b0000);
    emitted = emit ? row_w : 3'd0;

    lanes_fifo_write = emit ? row_mask : 4'b0000;
    lanes_fifo_data  = '0;
    for (int i = 0; i < 4; i++) begin
      if (lanes_fifo_write[i]) lanes_fifo_data[i*9 +: 9] = {lp_q, buf_q[i]};
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  pkt_ready = 1'b1;
      S_FILL:  pkt_ready = (count_q <= 4'd4);
      default: pkt_ready = 1'b0;
    endcase
    if (rst) pkt_ready = 1'b0;
  end

  assign accept = pkt_valid && pkt_ready;
  assign acc_n  = {2'b00, pkt_strb[0]} + {2'b00, pkt_strb[1]} +
                  {2'b00, pkt_strb[2]} + {2'b00, pkt_strb[3]};
  assign busy   = (state_q != S_IDLE);

  // Buffer update: drop the emitted head, then append accepted bytes in
  // low-to-high strobe order behind what remains.
  always_comb begin
    rem    = count_q - {1'b0, emitted};
    src    = '0;
    wr_pos = rem;
    for (int j = 0; j < 8; j++) begin
      src = 4'(j) + {1'b0, emitted};
      buf_d[j] = (src < 4'd8) ? buf_q[src[2:0]] : 8'h00;
    end
    if (accept) begin
      for (int b = 0; b < 4; b++) begin
        if (pkt_strb[b]) begin
          if (wr_pos < 4'd8) buf_d[wr_pos[2:0]] = pkt_data[b*8 +: 8];
          wr_pos = wr_pos + 4'd1;
        end
      end
    end
    count_d = rem + (accept ? {1'b0, acc_n} : 4'd0);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lp_d    = lp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d     = {1'b0, reg_lanes_number} + 3'd1;
          lp_d    = pkt_lp;
          state_d = pkt_last ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        if (accept && pkt_last) state_d = S_DRAIN;
      end
      default: begin
        if (count_d == 4'd0) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      n_q     <= 3'd1;
      lp_q    <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      lp_q    <= lp_d;
      buf_q   <= buf_d;
    end
  end

`ifdef DSI_LANES_DISTR_ERR_CHECK_EN
  logic err_q;
  logic strb_bad;

  always_comb begin
    case (pkt_strb)
      4'h0, 4'h1, 4'h3, 4'h7, 4'hF: strb_bad = 1'b0;
      default:                      strb_bad = 1'b1;
    endcase
    if (pkt_strb != 4'hF && !pkt_last) strb_bad = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) err_q <= 1'b0;
    else if (accept && strb_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// tb/tb_dsi_lanes_distributor.sv - directed self-checking bench for dsi_lanes_distributor

module tb_dsi_lanes_distributor;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [31:0] pkt_data;
  logic [3:0]  pkt_strb;
  logic        pkt_lp;
  logic        pkt_last;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  reg_lanes_number;
  logic [35:0] lanes_fifo_data;
  logic [3:0]  lanes_fifo_write;
  logic [3:0]  lanes_fifo_full;
  logic        busy;
  logic        err;

`ifdef DSI_LANES_DISTR_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] lane_q [4][$];

  dsi_lanes_distributor dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .pkt_data         (pkt_data),
    .pkt_strb         (pkt_strb),
    .pkt_lp           (pkt_lp),
    .pkt_last         (pkt_last),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (pkt_ready),
    .reg_lanes_number (reg_lanes_number),
    .lanes_fifo_data  (lanes_fifo_data),
    .lanes_fifo_write (lanes_fifo_write),
    .lanes_fifo_full  (lanes_fifo_full),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    for (int i = 0; i < 4; i++)
      if (lanes_fifo_write[i]) lane_q[i].push_back(lanes_fifo_data[i*9 +: 9]);
  end

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] row(input logic lp, input logic [3:0] m,
                                      input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3);
    logic [35:0] r;
    r = '0;
    if (m[0]) r[8:0]   = {lp, b0};
    if (m[1]) r[17:9]  = {lp, b1};
    if (m[2]) r[26:18] = {lp, b2};
    if (m[3]) r[35:27] = {lp, b3};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) lane_q[i].delete();
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic last);
    logic ok, r;
    ok = 1'b0;
    pkt_data = d; pkt_strb = s; pkt_last = last; pkt_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_sys);
      r = pkt_ready;
      tick();
      if (r) begin ok = 1'b1; break; end
    end
    pkt_valid = 1'b0; pkt_last = 1'b0;
    check("send_accepted", {35'd0, ok}, 36'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    check("idle_reached", {35'd0, busy}, 36'd0);
    tick();
  endtask

  // Byte k of a stream of consecutive bytes starting at base lands on lane k mod n.
  task automatic check_lanes(input string tag, input logic [7:0] base, input int nbytes,
                             input int n, input logic lp);
    int cnt;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      for (int k = 0; k < nbytes; k++) if (i < n && k % n == i) cnt++;
      check($sformatf("%s_lane%0d_len", tag, i), 36'(lane_q[i].size()), 36'(cnt));
      for (int j = 0; j < cnt && j < lane_q[i].size(); j++) begin
        b = base + 8'(i + j * n);
        check($sformatf("%s_lane%0d_b%0d", tag, i, j), {27'd0, lane_q[i][j]}, {27'd0, lp, b});
      end
    end
  endtask

  initial begin
    rst = 1'b1; pkt_data = '0; pkt_strb = '0; pkt_lp = 1'b0; pkt_last = 1'b0;
    pkt_valid = 1'b0; reg_lanes_number = 2'd0; lanes_fifo_full = 4'b0000;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ready", {35'd0, pkt_ready}, 36'd0);
    check("rst_write", {32'd0, lanes_fifo_write}, 36'd0);
    check("rst_data", lanes_fifo_data, 36'd0);
    check("rst_busy", {35'd0, busy}, 36'd0);
    check("rst_err", {35'd0, err}, 36'd0);
    tick();
    rst = 1'b0;

    // N=4, HS, two beats
    reg_lanes_number = 2'd3; pkt_lp = 1'b0;
    pkt_data = 32'h03020100; pkt_strb = 4'hF; pkt_last = 1'b0; pkt_valid = 1'b1;
    @(negedge clk_sys);
    check("t1_idle_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    pkt_data = 32'h07060504; pkt_last = 1'b1;
    @(negedge clk_sys);
    check("t1_row0_wr", {32'd0, lanes_fifo_write}, 36'hF);
    check("t1_row0_data", lanes_fifo_data, row(1'b0, 4'hF, 8'h00, 8'h01, 8'h02, 8'h03));
    check("t1_fill_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    pkt_valid = 1'b0; pkt_last = 1'b0;
    @(negedge clk_sys);
    check("t1_row1_wr", {32'd0, lanes_fifo_write}, 36'hF);
    check("t1_row1_data", lanes_fifo_data, row(1'b0, 4'hF, 8'h04, 8'h05, 8'h06, 8'h07));
    check("t1_drain_ready", {35'd0, pkt_ready}, 36'd0);
    check("t1_drain_busy", {35'd0, busy}, 36'd1);
    tick();
    @(negedge clk_sys);
    check("t1_end_wr", {32'd0, lanes_fifo_write}, 36'd0);
    check("t1_end_busy", {35'd0, busy}, 36'd0);
    tick();

    // N=3, LP, 10 bytes
    clear_lanes();
    reg_lanes_number = 2'd2; pkt_lp = 1'b1;
    send(32'h03020100, 4'hF, 1'b0);
    send(32'h07060504, 4'hF, 1'b0);
    send(32'hEEEE0908, 4'h3, 1'b1);
    wait_idle();
    check_lanes("t2", 8'h00, 10, 3, 1'b1);

    // N=2, lane 1 full for 5 cycles
    clear_lanes();
    reg_lanes_number = 2'd1; pkt_lp = 1'b0; lanes_fifo_full = 4'b0010;
    pkt_data = 32'h13121110; pkt_strb = 4'hF; pkt_last = 1'b0; pkt_valid = 1'b1;
    tick();
    pkt_data = 32'h17161514;
    @(negedge clk_sys);
    check("t3_stall0_wr", {32'd0, lanes_fifo_write}, 36'd0);
    check("t3_stall0_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    pkt_data = 32'h1B1A1918; pkt_last = 1'b1;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk_sys);
      check($sformatf("t3_stall%0d_wr", c), {32'd0, lanes_fifo_write}, 36'd0);
      check($sformatf("t3_stall%0d_ready", c), {35'd0, pkt_ready}, 36'd0);
      tick();
    end
    lanes_fifo_full = 4'b0000;
    send(32'h1B1A1918, 4'hF, 1'b1);
    wait_idle();
    check_lanes("t3", 8'h10, 12, 2, 1'b0);

    // N=1, single beat strb 7, then next packet starts on lane 0
    reg_lanes_number = 2'd0; pkt_lp = 1'b0;
    pkt_data = 32'hFFA2A1A0; pkt_strb = 4'h7; pkt_last = 1'b1; pkt_valid = 1'b1;
    @(negedge clk_sys);
    check("t4_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    pkt_valid = 1'b0; pkt_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      check($sformatf("t4_w%0d_wr", c), {32'd0, lanes_fifo_write}, 36'h1);
      check($sformatf("t4_w%0d_data", c), lanes_fifo_data, {27'd0, 1'b0, 8'hA0 + 8'(c)});
      check($sformatf("t4_w%0d_ready", c), {35'd0, pkt_ready}, 36'd0);
      tick();
    end
    @(negedge clk_sys);
    check("t4_idle_wr", {32'd0, lanes_fifo_write}, 36'd0);
    check("t4_idle_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    reg_lanes_number = 2'd1;
    pkt_data = 32'h00006655; pkt_strb = 4'h3; pkt_last = 1'b1; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; pkt_last = 1'b0;
    @(negedge clk_sys);
    check("t4_next_wr", {32'd0, lanes_fifo_write}, 36'h3);
    check("t4_next_data", lanes_fifo_data, row(1'b0, 4'h3, 8'h55, 8'h66, 8'h00, 8'h00));
    tick();
    wait_idle();

    // reset mid-packet with 6 bytes buffered
    reg_lanes_number = 2'd1;
    pkt_data = 32'h33221100; pkt_strb = 4'hF; pkt_last = 1'b0; pkt_valid = 1'b1;
    tick();
    pkt_data = 32'h77665544;
    @(negedge clk_sys);
    check("t5_row_wr", {32'd0, lanes_fifo_write}, 36'h3);
    tick();
    pkt_valid = 1'b0; rst = 1'b1;
    @(negedge clk_sys);
    check("t5_rst_wr", {32'd0, lanes_fifo_write}, 36'd0);
    check("t5_rst_ready", {35'd0, pkt_ready}, 36'd0);
    tick();
    rst = 1'b0;
    @(negedge clk_sys);
    check("t5_post_busy", {35'd0, busy}, 36'd0);
    check("t5_post_wr", {32'd0, lanes_fifo_write}, 36'd0);
    check("t5_post_ready", {35'd0, pkt_ready}, 36'd1);
    tick();
    reg_lanes_number = 2'd3;
    pkt_data = 32'hC3C2C1C0; pkt_strb = 4'hF; pkt_last = 1'b1; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; pkt_last = 1'b0;
    @(negedge clk_sys);
    check("t5_new_wr", {32'd0, lanes_fifo_write}, 36'hF);
    check("t5_new_data", lanes_fifo_data, row(1'b0, 4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3));
    tick();
    wait_idle();

    // protocol error: non-last beat with strb 7
    check("t6_err_before", {35'd0, err}, 36'd0);
    reg_lanes_number = 2'd3;
    send(32'h000000D0, 4'h7, 1'b0);
    @(negedge clk_sys);
    check("t6_err_set", {35'd0, err}, {35'd0, ERR_EXP});
    tick();
    send(32'h000000E0, 4'hF, 1'b1);
    wait_idle();
    check("t6_err_held", {35'd0, err}, {35'd0, ERR_EXP});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
